// File: rtl/kernel_pkg.sv
// Shared types for the kernel pipeline sequencing controller.
package kernel_pkg;
    localparam int KPC_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } kpc_state_e;
endpackage

// File: rtl/kernel_pipe_ctrl_if.sv
// Handshake bundle between the kernel wrapper/datapath and kernel_pipe_ctrl.
interface kernel_pipe_ctrl_if
    import kernel_pkg::*;
#(
    parameter int CNT_W = KPC_CNT_W
);
    logic             start;
    logic [CNT_W-1:0] nki;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             stall;
    logic             busy;
    logic             done;

    modport master (
        output start, nki, in_valid, out_ready,
        input  in_ready, out_valid, stall, busy, done
    );

    modport slave (
        input  start, nki, in_valid, out_ready,
        output in_ready, out_valid, stall, busy, done
    );
endinterface

// File: rtl/kpc_valid_shreg.sv
// Valid shadow of the datapath: DEPTH-deep shift register that freezes on hold.
module kpc_valid_shreg #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] vpipe;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (rst)        vpipe <= '0;
                else if (!hold) vpipe <= din;
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (rst)        vpipe <= '0;
                else if (!hold) vpipe <= {vpipe[DEPTH-2:0], din};
            end
        end
    endgenerate

    assign dout = vpipe[DEPTH-1];
endmodule

// File: rtl/kernel_pipe_ctrl.sv
// Sequencing controller for one kernel invocation over a fixed-latency map pipeline.
// Optional KPC_PERF_EN adds saturating stall/bubble cycle counters.
module kernel_pipe_ctrl
    import kernel_pkg::*;
#(
    parameter int PIPE_DEPTH = 1,
    parameter int CNT_W      = KPC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    kernel_pipe_ctrl_if.slave bus
`ifdef KPC_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_cycles
`endif
);
    kpc_state_e       state, state_nxt;
    logic [CNT_W-1:0] nki_q, issued, retired, issued_nxt, retired_nxt;
    logic             vld_last, out_valid, stall, in_ready, busy;
    logic             accept, retire, start_ok;

    // Outputs are forced low while rst is held so the wrapper sees a quiet block.
    assign out_valid = vld_last & ~rst;
    assign stall     = out_valid & ~bus.out_ready;
    assign in_ready  = ~rst & (state == RUN) & ~stall & (issued != nki_q);
    assign busy      = ~rst & ((state == RUN) | (state == DRAIN));
    assign accept    = bus.in_valid & in_ready;
    assign retire    = out_valid & bus.out_ready;
    assign start_ok  = (state == IDLE) & bus.start;

    assign issued_nxt  = issued  + {{(CNT_W-1){1'b0}}, accept};
    assign retired_nxt = retired + {{(CNT_W-1){1'b0}}, retire};

    assign bus.out_valid = out_valid;
    assign bus.stall     = stall;
    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.done      = ~rst & (state == DONE);

    kpc_valid_shreg #(.DEPTH(PIPE_DEPTH)) u_vpipe (
        .clk  (clk),
        .rst  (rst),
        .hold (stall),
        .din  (accept),
        .dout (vld_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Transitions look at the post-event counts so RUN/DRAIN end one cycle after the last event.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.nki == '0) ? DONE : RUN;
            RUN:     if (issued_nxt == nki_q) state_nxt = DRAIN;
            DRAIN:   if (retired_nxt == nki_q) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nki_q   <= '0;
            issued  <= '0;
            retired <= '0;
        end else if (start_ok) begin
            nki_q   <= bus.nki;
            issued  <= '0;
            retired <= '0;
        end else begin
            issued  <= issued_nxt;
            retired <= retired_nxt;
        end
    end

`ifdef KPC_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            stall_cycles  <= '0;
            bubble_cycles <= '0;
        end else begin
            if (busy && stall && !(&stall_cycles))
                stall_cycles <= stall_cycles + 1'b1;
            if ((state == RUN) && in_ready && !bus.in_valid && !(&bubble_cycles))
                bubble_cycles <= bubble_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_kernel_pipe_ctrl.sv
// Directed bench for kernel_pipe_ctrl: cycle tables for depth 1 and 3, plus corner sequences.
module tb_kernel_pipe_ctrl;
    import kernel_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst3;
    kernel_pipe_ctrl_if #(.CNT_W(32)) b1 ();
    kernel_pipe_ctrl_if #(.CNT_W(32)) b3 ();
`ifdef KPC_PERF_EN
    logic [31:0] sc1, bc1, sc3, bc3;
`endif

    kernel_pipe_ctrl #(.PIPE_DEPTH(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst(rst1), .bus(b1)
`ifdef KPC_PERF_EN
        , .stall_cycles(sc1), .bubble_cycles(bc1)
`endif
    );

    kernel_pipe_ctrl #(.PIPE_DEPTH(3), .CNT_W(32)) u_dut3 (
        .clk(clk), .rst(rst3), .bus(b3)
`ifdef KPC_PERF_EN
        , .stall_cycles(sc3), .bubble_cycles(bc3)
`endif
    );

    // exp = {in_ready, out_valid, stall, busy, done}
    typedef struct {
        bit          sel;
        bit          rst;
        bit          start;
        logic [31:0] nki;
        bit          iv;
        bit          ordy;
        logic [4:0]  exp;
        bit          cvp;
        logic [2:0]  vp;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int failures = 0;

    function automatic vec_t mk(bit sel, bit r, bit s, int n, bit iv, bit o, logic [4:0] e);
        vec_t v;
        v.sel = sel; v.rst = r; v.start = s; v.nki = 32'(n);
        v.iv = iv; v.ordy = o; v.exp = e; v.cvp = 1'b0; v.vp = 3'b000;
        return v;
    endfunction

    task automatic drive(bit sel, bit r, bit s, logic [31:0] n, bit iv, bit o);
        if (sel) begin
            rst3 = r; b3.start = s; b3.nki = n; b3.in_valid = iv; b3.out_ready = o;
        end else begin
            rst1 = r; b1.start = s; b1.nki = n; b1.in_valid = iv; b1.out_ready = o;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs(bit sel);
        if (sel) return {b3.in_ready, b3.out_valid, b3.stall, b3.busy, b3.done};
        return {b1.in_ready, b1.out_valid, b1.stall, b1.busy, b1.done};
    endfunction

    int retires3 = 0;

    initial begin
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);

        // depth 1, nki=4, free-flowing
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk(0, 0, 1, 4, 1, 1, 5'b00000));
        tbl.push_back(mk(0, 0, 0, 4, 1, 1, 5'b10010));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 4, 1, 1, 5'b11010));
        tbl.push_back(mk(0, 0, 0, 4, 1, 1, 5'b01010));
        tbl.push_back(mk(0, 0, 0, 4, 1, 1, 5'b00001));
        tbl.push_back(mk(0, 0, 0, 4, 1, 1, 5'b00000));
        // nki=0 goes straight to DONE
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 5'b00000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 5'b00001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 5'b00000));
        // reset with issued=2, then a clean nki=1 invocation
        tbl.push_back(mk(0, 0, 1, 5, 1, 1, 5'b00000));
        tbl.push_back(mk(0, 0, 0, 5, 1, 1, 5'b10010));
        tbl.push_back(mk(0, 0, 0, 5, 1, 1, 5'b11010));
        tbl.push_back(mk(0, 1, 0, 5, 1, 1, 5'b00000));
        tbl.push_back(mk(0, 0, 0, 5, 1, 1, 5'b00000));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 5'b00000));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 5'b10010));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 5'b01010));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 5'b00001));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 5'b00000));
        // depth 3, nki=5, backpressure in cycles 5-7
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk(1, 0, 1, 5, 1, 1, 5'b00000));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 5, 1, 1, 5'b10010));
        tbl.push_back(mk(1, 0, 0, 5, 1, 1, 5'b11010));
        for (int i = 0; i < 3; i++) begin
            vec_t v;
            v = mk(1, 0, 0, 5, 1, 0, 5'b01110);
            v.cvp = 1'b1; v.vp = 3'b111;
            tbl.push_back(v);
        end
        tbl.push_back(mk(1, 0, 0, 5, 1, 1, 5'b11010));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 5, 1, 1, 5'b01010));
        tbl.push_back(mk(1, 0, 0, 5, 1, 1, 5'b00001));
        tbl.push_back(mk(1, 0, 0, 5, 1, 1, 5'b00000));

        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sel, tbl[i].rst, tbl[i].start, tbl[i].nki, tbl[i].iv, tbl[i].ordy);
            #2;
            chk($sformatf("vec%0d_outs", i), 32'(outs(tbl[i].sel)), 32'(tbl[i].exp));
            if (tbl[i].cvp)
                chk($sformatf("vec%0d_vpipe", i), 32'(u_dut3.u_vpipe.vpipe), 32'(tbl[i].vp));
            if (tbl[i].sel && b3.out_valid && b3.out_ready) retires3++;
            @(posedge clk); #1;
        end
        chk("depth3_retires", 32'(retires3), 32'd5);

        // start during RUN with a different nki is ignored
        begin
            int acc = 0, ret = 0, dn = 0;
            for (int c = 0; c < 20; c++) begin
                drive(1'b0, 1'b0, (c == 0) || (c == 2), (c == 2) ? 32'd7 : 32'd3, 1'b1, 1'b1);
                #2;
                if (b1.in_valid && b1.in_ready) acc++;
                if (b1.out_valid && b1.out_ready) ret++;
                if (b1.done) dn++;
                @(posedge clk); #1;
            end
            chk("restart_accepts", 32'(acc), 32'd3);
            chk("restart_retires", 32'(ret), 32'd3);
            chk("restart_dones", 32'(dn), 32'd1);
        end

`ifdef KPC_PERF_EN
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 30; c++) begin
                drive(1'b0, 1'b0, c == 0, 32'd4, !(c == 2 || c == 3), c != 5);
                #2;
                if (b1.done) begin
                    seen = 1'b1;
                    chk("perf_bubble", bc1, 32'd2);
                    chk("perf_stall", sc1, 32'd1);
                end
                @(posedge clk); #1;
            end
            chk("perf_done_seen", 32'(seen), 32'd1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kernel_pipe_ctrl.md
Name: kernel_pipe_ctrl

Overview:
- Sequencing controller for a chain of registered leaf map nodes. Each node has a registered output, a stall input, and a fixed per-stage latency.
- Runs one kernel invocation of NKI work items: accepts items upstream, tracks item validity through the datapath latency, and drives the shared stall line.
- Applies downstream backpressure and reports busy/done to the enclosing kernel wrapper.
- Sits beside the datapath: stall fans out to every node; out_valid travels with the datapath output.

Parameters:
- PIPE_DEPTH, 1, datapath latency in clock cycles (>=1); length of the valid-tracking shift register.
- CNT_W, 32, width of the work-item count and the issue/retire counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin invocation; sampled only in IDLE.
- nki  in  CNT_W  work items in this invocation; latched on start.
- in_valid  in  1  upstream item present on the datapath inputs.
- in_ready  out  1  item accepted this cycle when in_valid & in_ready.
- out_valid  out  1  datapath output register holds a valid item.
- out_ready  in  1  downstream accepts the output this cycle.
- stall  out  1  freeze all datapath stage registers.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the invocation completes.

Behaviour:
- Reset: state=IDLE; vpipe, issued, retired and nki_q all cleared. Outputs during reset: in_ready=0, out_valid=0, stall=0, busy=0, done=0.
- Reset mid-invocation aborts with no done pulse and discards in-flight items.
- vpipe[PIPE_DEPTH-1:0]: valid shadow of the datapath. out_valid = vpipe[PIPE_DEPTH-1].
- stall = out_valid & ~out_ready (combinational). When stall=0, vpipe shifts by one every cycle, with bit 0 loaded from the accept event (bubbles advance). When stall=1, vpipe holds.
- in_ready = (state==RUN) & ~stall & (issued != nki_q).
- Accept event = in_valid & in_ready; issued increments on it.
- Retire event = out_valid & out_ready; retired increments on it.
- Minimum latency: an item accepted in cycle t is presented with out_valid in cycle t+PIPE_DEPTH.
- Throughput: 1 item/cycle with no backpressure.
- IDLE: on start, latch nki into nki_q. If nki==0 go to DONE; otherwise go to RUN. start outside IDLE is ignored.
- RUN: go to DRAIN in the cycle after issued reaches nki_q.
- DRAIN: in_ready=0. Go to DONE in the cycle after retired reaches nki_q.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE.
- A simultaneous accept and retire in one cycle are both counted.
- Counters are not checked for wrap; nki up to 2^CNT_W-1 is legal.
- A stall raised while in_valid=1 blocks acceptance; no item is lost or duplicated.

Optional Feature:
- Macro KPC_PERF_EN.
- Defined: adds output ports stall_cycles[CNT_W-1:0] and bubble_cycles[CNT_W-1:0].
  - stall_cycles counts cycles with busy & stall.
  - bubble_cycles counts cycles in RUN with in_ready & ~in_valid.
  - Both are cleared on rst and on an accepted start; they saturate at all-ones.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package kernel_pkg:
  - state enum: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3.
  - default CNT_W.
- One natural sub-module: kpc_valid_shreg, a PIPE_DEPTH-deep shift register with hold enable, instantiated once for vpipe. Counters and FSM stay in the top module.

Test Plan:
- PIPE_DEPTH=1, nki=4, in_valid=1 and out_ready=1 constant, start pulsed in cycle 0:
  - accepts in cycles 1-4; out_valid in cycles 2-5; done=1 in cycle 6 only.
  - busy high in cycles 1-5; stall never asserted.
- PIPE_DEPTH=3, nki=5, out_ready held low in cycles 5-7:
  - stall=1 in cycles 5-7; in_ready=0 in cycles 5-7; vpipe frozen.
  - exactly 5 retires; done one cycle after the 5th retire.
- nki=0 with start: DONE next cycle, done pulse, in_ready never high, busy never high.
- rst asserted in RUN with issued=2:
  - next cycle all outputs are 0 and state is IDLE, no done pulse.
  - a new start with nki=1 completes normally.
- start pulsed during RUN with nki=7 (first invocation nki=3): ignored; done fires after 3 items.
- KPC_PERF_EN defined, PIPE_DEPTH=1, nki=4, in_valid low in cycles 2-3, out_ready low in one cycle:
  - bubble_cycles=2, stall_cycles=1 at done.
